// File: rtl/detector_share_ctrl.sv
// detector_share_ctrl: time-shares a single 1094 sequence detector among
// NUM_REQ code sources. A granted requester loads a 4-digit frame. The frame
// is replayed to the detector, followed by one idle digit. The registered
// detector pattern is then returned to that requester as a match/error result.
module detector_share_ctrl #(
  parameter int         NUM_REQ      = 2,
  parameter int         LOAD_TIMEOUT = 16,
  parameter logic [3:0] IDLE_DIGIT   = 4'hF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_digit,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   res_valid,
  output logic                 res_match,
  output logic                 res_error,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [3:0]           det_number,
  input  logic                 det_pattern
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    FLUSH  = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Last idle cycle allowed in LOAD before the frame is abandoned
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);
  localparam logic [7:0] TIMEOUT_MAX  = 8'(LOAD_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [2:0] rr_ptr;
  logic [3:0] buffer [4];
  logic [2:0] count;
  logic [7:0] tcount;
  logic [1:0] run_idx;

  logic       sel_valid;
  logic [3:0] sel_digit;
  logic       accept;
  logic       timeout_hit;
  logic       arb_found;
  logic [2:0] arb_id;
  logic [2:0] next_rr;
  int         arb_idx;

  // Select the granted requester's valid and digit lanes
  always_comb begin
    sel_valid = 1'b0;
    sel_digit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_digit = req_digit[4*i +: 4];
      end
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      arb_idx = int'(rr_ptr) + off;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_id    = 3'(arb_idx);
      end
    end
  end

  assign accept      = (state == LOAD) && sel_valid;
  assign timeout_hit = (tcount >= TIMEOUT_LAST);
  assign next_rr     = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus the decoded ready/result strobes
  always_comb begin
    state_next = state;
    req_ready  = '0;
    res_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        req_ready[i] = (state == LOAD);
        res_valid[i] = (state == REPORT);
      end
    end
    case (state)
      IDLE:    if (arb_found) state_next = LOAD;
      LOAD: begin
        if (accept && (count == 3'd3))  state_next = RUN;
        else if (!accept && timeout_hit) state_next = REPORT;
      end
      RUN:     if (run_idx == 2'd3) state_next = FLUSH;
      FLUSH:   state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: grant capture, digit buffer, replay, result flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_id   <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      tcount     <= '0;
      run_idx    <= '0;
      det_number <= IDLE_DIGIT;
      res_match  <= 1'b0;
      res_error  <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < 4; i++) buffer[i] <= '0;
    end else begin
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_id;
            tcount   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            buffer[count[1:0]] <= sel_digit;
            count              <= count + 3'd1;
            tcount             <= '0;
            if (count == 3'd3) begin
              det_number <= buffer[0];
              run_idx    <= 2'd0;
            end
          end else begin
            if (tcount != TIMEOUT_MAX) tcount <= tcount + 8'd1;
            if (timeout_hit) begin
              res_error <= 1'b1;
              res_match <= 1'b0;
            end
          end
        end
        RUN: begin
          if (run_idx == 2'd3) det_number <= IDLE_DIGIT;
          else                 det_number <= buffer[run_idx + 2'd1];
          run_idx <= run_idx + 2'd1;
        end
        FLUSH: begin
          res_match <= det_pattern;
          res_error <= 1'b0;
        end
        REPORT: begin
          rr_ptr <= next_rr;
          count  <= '0;
          tcount <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_share_ctrl.sv
// Bench for detector_share_ctrl. It has a stand-in 1094 detector and queued
// digit sources for each requester. A frame-level reference model is compared
// against the DUT every cycle, and directed literal checks are added on top.
module tb_detector_share_ctrl;

  localparam int NUM_REQ      = 2;
  localparam int LOAD_TIMEOUT = 16;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [4*NUM_REQ-1:0] req_digit = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   res_valid;
  logic                 res_match;
  logic                 res_error;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [3:0]           det_number;
  logic                 det_pattern = 1'b0;

  detector_share_ctrl #(
    .NUM_REQ(NUM_REQ), .LOAD_TIMEOUT(LOAD_TIMEOUT), .IDLE_DIGIT(4'hF)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_digit(req_digit), .req_ready(req_ready),
    .res_valid(res_valid), .res_match(res_match), .res_error(res_error),
    .grant_id(grant_id), .busy(busy), .det_number(det_number),
    .det_pattern(det_pattern)
  );

  // Free-running clock
  initial forever #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic check_output(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stand-in detector (no reset, registered pattern) -------
  int det_progress = 0;

  function automatic logic [3:0] code_digit(int p);
    case (p)
      0: return 4'd1;
      1: return 4'd0;
      2: return 4'd9;
      default: return 4'd4;
    endcase
  endfunction

  // Detector: pulse pattern the cycle after the 4th digit of 1,0,9,4 arrives
  always @(posedge clock) begin
    if (det_number == code_digit(det_progress)) begin
      if (det_progress == 3) begin
        det_pattern <= 1'b1;
        det_progress = 0;
      end else begin
        det_pattern <= 1'b0;
        det_progress = det_progress + 1;
      end
    end else begin
      det_pattern <= 1'b0;
      det_progress = (det_number == 4'd1) ? 1 : 0;
    end
  end

  // ---------------- requester digit sources -----------------------------
  logic [3:0] src_mem [NUM_REQ][64];
  int src_head [NUM_REQ] = '{default: 0};
  int src_tail [NUM_REQ] = '{default: 0};
  int cyc = 0;
  int acc_cyc = 0;

  task automatic push(int r, logic [3:0] d);
    src_mem[r][src_tail[r]] = d;
    src_tail[r]++;
  endtask

  task automatic push4(int r, logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    push(r, a); push(r, b); push(r, c); push(r, d);
  endtask

  // Sources: retire accepted digits, then present the next queued digit
  always @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        src_head[i]++;
        acc_cyc = cyc;
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req_valid[i]         = 1'b1;
        req_digit[4*i +: 4]  = src_mem[i][src_head[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_digit[4*i +: 4]  = 4'd0;
      end
    end
  end

  // ---------------- frame-level reference model -------------------------
  typedef struct packed {
    logic [3:0] det;
    logic       rep;
    logic       m;
    logic       e;
  } slot_t;

  slot_t      tail_q[$];
  int         owner_m = 0;
  bit         loading = 1'b0;
  logic [3:0] got [4];
  int         ngot = 0;
  int         quiet = 0;
  int         rr_m = 0;
  bit         e_match = 1'b0;
  bit         e_err = 1'b0;
  bit         m_found;
  int         m_idx;

  function automatic slot_t mk(logic [3:0] d, logic r, logic m, logic e);
    slot_t s;
    s.det = d; s.rep = r; s.m = m; s.e = e;
    return s;
  endfunction

  // Model: a granted frame collects 4 digits, then schedules its replay tail
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tail_q.delete();
      owner_m = 0; loading = 1'b0; ngot = 0; quiet = 0; rr_m = 0;
      e_match = 1'b0; e_err = 1'b0;
    end else begin
      if (tail_q.size() > 0) begin
        if (tail_q[0].rep) rr_m = (owner_m + 1) % NUM_REQ;
        void'(tail_q.pop_front());
      end else if (loading) begin
        if (req_valid[owner_m]) begin
          got[ngot] = req_digit[4*owner_m +: 4];
          ngot++;
          quiet = 0;
          if (ngot == 4) begin
            loading = 1'b0;
            for (int k = 0; k < 4; k++) tail_q.push_back(mk(got[k], 1'b0, 1'b0, 1'b0));
            tail_q.push_back(mk(4'hF, 1'b0, 1'b0, 1'b0));
            tail_q.push_back(mk(4'hF, 1'b1,
              (got[0] == 4'd1 && got[1] == 4'd0 && got[2] == 4'd9 && got[3] == 4'd4), 1'b0));
          end
        end else begin
          quiet++;
          if (quiet == LOAD_TIMEOUT) begin
            loading = 1'b0;
            tail_q.push_back(mk(4'hF, 1'b1, 1'b0, 1'b1));
          end
        end
      end else begin
        m_found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
          m_idx = (rr_m + off) % NUM_REQ;
          if (!m_found && req_valid[m_idx]) begin
            m_found = 1'b1;
            owner_m = m_idx;
            loading = 1'b1;
            ngot = 0;
            quiet = 0;
          end
        end
      end
      if (tail_q.size() > 0 && tail_q[0].rep) begin
        e_match = tail_q[0].m;
        e_err   = tail_q[0].e;
      end
    end
  end

  // ---------------- per-cycle compare and result log --------------------
  int rep_count = 0;
  int rep_idx   [64];
  int rep_match [64];
  int rep_err   [64];
  int rep_cyc   [64];
  int run_digits = 0;
  int pat_cnt = 0;
  int exp_ready;
  int exp_rv;
  int exp_det;

  // Compare every output with the model away from the rising edge
  always @(negedge clock) begin
    if (started) begin
      exp_ready = loading ? (1 << owner_m) : 0;
      exp_rv    = (tail_q.size() > 0 && tail_q[0].rep) ? (1 << owner_m) : 0;
      exp_det   = (tail_q.size() > 0) ? int'(tail_q[0].det) : 15;
      check_output("req_ready", int'(req_ready), exp_ready);
      check_output("res_valid", int'(res_valid), exp_rv);
      check_output("busy", int'(busy), int'(loading || tail_q.size() > 0));
      check_output("det_number", int'(det_number), exp_det);
      check_output("grant_id", int'(grant_id), owner_m);
      check_output("res_match", int'(res_match), int'(e_match));
      check_output("res_error", int'(res_error), int'(e_err));
      if (det_number != 4'hF) run_digits++;
      if (det_pattern) pat_cnt++;
      if (res_valid != '0 && rep_count < 64) begin
        for (int i = 0; i < NUM_REQ; i++) if (res_valid[i]) rep_idx[rep_count] = i;
        rep_match[rep_count] = int'(res_match);
        rep_err[rep_count]   = int'(res_error);
        rep_cyc[rep_count]   = cyc;
        rep_count++;
      end
    end
  end

  task automatic wait_reports(int n, int budget);
    int k = 0;
    while (rep_count < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    if (rep_count < n) check_output("report_wait", rep_count, n);
  endtask

  // ---------------- directed stimulus -----------------------------------
  task automatic apply_stimulus();
    int base;
    int base_aux;
    bit found;

    // Single requester 0, frame 1094
    @(negedge clock);
    push4(0, 4'd1, 4'd0, 4'd9, 4'd4);
    wait_reports(1, 60);
    check_output("t1_idx", rep_idx[0], 0);
    check_output("t1_match", rep_match[0], 1);
    check_output("t1_error", rep_err[0], 0);
    check_output("t1_latency", rep_cyc[0] - acc_cyc, 6);

    // Requester 1, frame 1095: no pattern pulse, no match
    @(negedge clock);
    base_aux = pat_cnt;
    push4(1, 4'd1, 4'd0, 4'd9, 4'd5);
    wait_reports(2, 60);
    check_output("t2_idx", rep_idx[1], 1);
    check_output("t2_match", rep_match[1], 0);
    check_output("t2_pattern", pat_cnt - base_aux, 0);

    // Both requesters continuously valid: grants alternate, 11-cycle frames
    @(negedge clock);
    push4(0, 4'd1, 4'd0, 4'd9, 4'd4); push4(0, 4'd1, 4'd0, 4'd9, 4'd4);
    push4(1, 4'd1, 4'd0, 4'd9, 4'd4); push4(1, 4'd1, 4'd0, 4'd9, 4'd4);
    wait_reports(6, 120);
    for (int j = 0; j < 4; j++) begin
      check_output("t3_idx", rep_idx[2 + j], j % 2);
      check_output("t3_match", rep_match[2 + j], 1);
    end
    for (int j = 0; j < 3; j++) check_output("t3_period", rep_cyc[3 + j] - rep_cyc[2 + j], 11);

    // Requester 0 stalls after 2 digits; requester 1 waits its turn
    @(negedge clock);
    base_aux = run_digits;
    push(0, 4'd1); push(0, 4'd0);
    push4(1, 4'd1, 4'd0, 4'd9, 4'd4);
    wait_reports(7, 80);
    check_output("t4_idx", rep_idx[6], 0);
    check_output("t4_error", rep_err[6], 1);
    check_output("t4_match", rep_match[6], 0);
    check_output("t4_timeout_lat", rep_cyc[6] - acc_cyc, 17);
    check_output("t4_no_replay", run_digits - base_aux, 0);
    wait_reports(8, 60);
    check_output("t4_next_idx", rep_idx[7], 1);
    check_output("t4_next_match", rep_match[7], 1);
    check_output("t4_next_error", rep_err[7], 0);

    // Frames 1010 then 9410 back to back: no carry-over match
    @(negedge clock);
    push4(0, 4'd1, 4'd0, 4'd1, 4'd0);
    push4(0, 4'd9, 4'd4, 4'd1, 4'd0);
    wait_reports(10, 120);
    check_output("t5_match_a", rep_match[8], 0);
    check_output("t5_match_b", rep_match[9], 0);

    // Reset in the middle of replay, then a fresh frame
    @(negedge clock);
    push4(0, 4'd1, 4'd0, 4'd9, 4'd4);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clock);
      #1;
      if (busy && det_number == 4'd0) found = 1'b1;
    end
    check_output("t6_reached_run", int'(found), 1);
    base = rep_count;
    #1 reset_n = 1'b0;
    #1;
    check_output("t6_rst_det", int'(det_number), 15);
    check_output("t6_rst_busy", int'(busy), 0);
    check_output("t6_rst_ready", int'(req_ready), 0);
    check_output("t6_rst_rvalid", int'(res_valid), 0);
    check_output("t6_rst_grant", int'(grant_id), 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check_output("t6_no_report", rep_count, base);
    push4(0, 4'd1, 4'd0, 4'd9, 4'd4);
    wait_reports(base + 1, 60);
    check_output("t6_fresh_idx", rep_idx[base], 0);
    check_output("t6_fresh_match", rep_match[base], 1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    started = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);
    apply_stimulus();
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
